// File: rtl/sdram_init_refresh_pkg.sv
// Shared definitions for the SDRAM init/refresh sequencer: command encodings,
// FSM states and refresh-credit thresholds.
package sdram_init_refresh_pkg;

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_INIT_PRE,
    ST_INIT_TRP,
    ST_INIT_REF,
    ST_INIT_TRC,
    ST_INIT_MRS,
    ST_INIT_TMRD,
    ST_IDLE,
    ST_REF_CMD,
    ST_REF_TRC
  } state_t;

  // Command vector ordering: {CS_n, RAS_n, CAS_n, WE_n}
  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_DESEL = 4'b1111;
  localparam cmd_t CMD_NOP   = 4'b0111;
  localparam cmd_t CMD_PRE   = 4'b0010;
  localparam cmd_t CMD_REF   = 4'b0001;
  localparam cmd_t CMD_MRS   = 4'b0000;

  localparam int          OWED_W           = 4;
  localparam logic [3:0]  URGENT_THRESHOLD = 4'd4;
  localparam logic [3:0]  OWED_MAX         = 4'd8;

  function automatic cmd_t state_cmd(input state_t s);
    case (s)
      ST_INIT_PRE:             return CMD_PRE;
      ST_INIT_REF, ST_REF_CMD: return CMD_REF;
      ST_INIT_MRS:             return CMD_MRS;
      default:                 return CMD_NOP;
    endcase
  endfunction

endpackage

// File: rtl/sdram_init_refresh_timer.sv
// Refresh interval down-counter plus the saturating count of owed refreshes.
module sdram_init_refresh_timer
  import sdram_init_refresh_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_tick_en,
  input  logic              i_consume,
  output logic [OWED_W-1:0] o_owed,
  output logic              o_overrun
);

  localparam int CNT_W = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [OWED_W-1:0] r_owed;
  logic              r_overrun;
  logic              w_tick;

  assign w_tick = i_tick_en && (r_cnt == '0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= RELOAD;
      r_owed    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (i_tick_en) r_cnt <= w_tick ? RELOAD : r_cnt - 1'b1;

      // A tick and a consume on the same edge cancel out, even when saturated.
      if (w_tick && !i_consume && r_owed != OWED_MAX) r_owed <= r_owed + 1'b1;
      else if (!w_tick && i_consume && r_owed != '0)  r_owed <= r_owed - 1'b1;

      if (w_tick && r_owed == OWED_MAX) r_overrun <= 1'b1;
    end
  end

  assign o_owed    = r_owed;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up init and periodic auto-refresh sequencer; owns the command
// bus during init and refresh. SDRAM_REFRESH_BURST_EN enables back-to-back drain.
module sdram_init_refresh
  import sdram_init_refresh_pkg::*;
#(
  parameter int          INIT_WAIT_CYCLES = 20000,
  parameter int          REFRESH_INTERVAL = 780,
  parameter int          T_RP             = 2,
  parameter int          T_RC             = 7,
  parameter int          T_MRD            = 2,
  parameter int          INIT_REFRESHES   = 8,
  parameter logic [11:0] MODE_WORD        = 12'h020
) (
  input  logic        MEMCLK,
  input  logic        RESET_n,
  input  logic        ram_busy,
  input  logic        ram_req,
  output logic        owns_bus,
  output logic        ref_hold,
  output logic        init_done,
  output logic        ref_overrun,
  output logic        CKE,
  output logic        CS_n,
  output logic        RAS_n,
  output logic        CAS_n,
  output logic        WE_n,
  output logic [11:0] MA,
  output logic [1:0]  BA
);

  // Wait states leave when the in-state counter reaches (duration - 1).
  localparam logic [15:0] L_INIT_WAIT = 16'(INIT_WAIT_CYCLES - 1);
  localparam logic [15:0] L_TRP       = 16'(T_RP - 2);
  localparam logic [15:0] L_TRC       = 16'(T_RC - 2);
  localparam logic [15:0] L_TMRD      = 16'(T_MRD - 2);
  localparam logic [7:0]  L_INIT_REFS = 8'(INIT_REFRESHES);

  state_t            r_state;
  state_t            w_next_state;
  logic [15:0]       r_cnt;
  logic [7:0]        r_init_refs;
  logic [15:0]       w_wait_last;
  logic              w_wait_done;
  logic [OWED_W-1:0] w_owed;
  logic              w_urgent;
  logic              w_consume;
  logic              w_overrun;

  logic              r_cke;
  cmd_t              r_cmd;
  logic [11:0]       r_ma;
  logic [1:0]        r_ba;
  logic              r_owns_bus;
  logic              r_ref_hold;
  logic              r_init_done;

  sdram_init_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_timer (
    .clk      (MEMCLK),
    .rst_n    (RESET_n),
    .i_tick_en(r_init_done),
    .i_consume(w_consume),
    .o_owed   (w_owed),
    .o_overrun(w_overrun)
  );

  assign w_urgent  = (w_owed >= URGENT_THRESHOLD);
  assign w_consume = (w_next_state == ST_REF_CMD);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_wait_last = '0;
    case (r_state)
      ST_INIT_WAIT:           w_wait_last = L_INIT_WAIT;
      ST_INIT_TRP:            w_wait_last = L_TRP;
      ST_INIT_TRC, ST_REF_TRC: w_wait_last = L_TRC;
      ST_INIT_TMRD:           w_wait_last = L_TMRD;
      default:                w_wait_last = '0;
    endcase
  end

  assign w_wait_done = (r_cnt == w_wait_last);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT_WAIT: if (w_wait_done) w_next_state = ST_INIT_PRE;
      ST_INIT_PRE:  w_next_state = ST_INIT_TRP;
      ST_INIT_TRP:  if (w_wait_done) w_next_state = ST_INIT_REF;
      ST_INIT_REF:  w_next_state = ST_INIT_TRC;
      ST_INIT_TRC:
        if (w_wait_done)
          w_next_state = (r_init_refs == L_INIT_REFS) ? ST_INIT_MRS : ST_INIT_REF;
      ST_INIT_MRS:  w_next_state = ST_INIT_TMRD;
      ST_INIT_TMRD: if (w_wait_done) w_next_state = ST_IDLE;
      // The access engine wins ties until the owed count turns urgent.
      ST_IDLE:
        if (w_owed != '0 && !ram_busy && (w_urgent || !ram_req))
          w_next_state = ST_REF_CMD;
      ST_REF_CMD:   w_next_state = ST_REF_TRC;
      ST_REF_TRC: begin
        if (w_wait_done) begin
`ifdef SDRAM_REFRESH_BURST_EN
          w_next_state = (w_owed != '0 && !ram_busy) ? ST_REF_CMD : ST_IDLE;
`else
          w_next_state = ST_IDLE;
`endif
        end
      end
      default:      w_next_state = ST_INIT_WAIT;
    endcase
  end

  // Outputs are registered from the current state, so each command reaches
  // the pins one cycle after its state is entered.
  always_ff @(posedge MEMCLK) begin
    if (!RESET_n) begin
      r_state     <= ST_INIT_WAIT;
      r_cnt       <= '0;
      r_init_refs <= '0;
      r_cke       <= 1'b0;
      r_cmd       <= CMD_DESEL;
      r_ma        <= '0;
      r_ba        <= '0;
      r_owns_bus  <= 1'b1;
      r_ref_hold  <= 1'b1;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= (w_next_state != r_state) ? '0 : r_cnt + 1'b1;
      if (r_state == ST_INIT_REF) r_init_refs <= r_init_refs + 1'b1;

      r_cke      <= 1'b1;
      r_cmd      <= state_cmd(r_state);
      r_ma       <= (r_state == ST_INIT_PRE) ? 12'h400 :
                    (r_state == ST_INIT_MRS) ? MODE_WORD : 12'h000;
      r_ba       <= 2'b00;
      r_owns_bus <= (r_state != ST_IDLE);
      r_ref_hold <= (r_state != ST_IDLE) || w_urgent || (w_next_state == ST_REF_CMD);
      if (r_state == ST_IDLE) r_init_done <= 1'b1;
    end
  end

  assign CKE                    = r_cke;
  assign {CS_n, RAS_n, CAS_n, WE_n} = r_cmd;
  assign MA                     = r_ma;
  assign BA                     = r_ba;
  assign owns_bus               = r_owns_bus;
  assign ref_hold               = r_ref_hold;
  assign init_done              = r_init_done;
  assign ref_overrun            = w_overrun;

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Scoreboard bench for sdram_init_refresh: an arithmetic reference model
// predicts commands and flags per edge; a monitor compares the pins.
`timescale 1ns/1ps
module tb_sdram_init_refresh;

  localparam int W    = 16;
  localparam int NREF = 2;
  localparam int RI   = 20;
  localparam int TRP  = 2;
  localparam int TRC  = 7;
  localparam int TMRD = 2;
  localparam logic [11:0] MODE = 12'h020;
  // Edge index (0 = first edge with reset released) at which init_done appears.
  localparam int D = W + TRP + NREF * TRC + TMRD;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;

  logic        MEMCLK = 1'b0;
  logic        RESET_n;
  logic        ram_busy;
  logic        ram_req;
  logic        owns_bus, ref_hold, init_done, ref_overrun;
  logic        CKE, CS_n, RAS_n, CAS_n, WE_n;
  logic [11:0] MA;
  logic [1:0]  BA;

  always #5 MEMCLK = ~MEMCLK;

  sdram_init_refresh #(
    .INIT_WAIT_CYCLES(W),
    .REFRESH_INTERVAL(RI),
    .T_RP            (TRP),
    .T_RC            (TRC),
    .T_MRD           (TMRD),
    .INIT_REFRESHES  (NREF),
    .MODE_WORD       (MODE)
  ) dut (
    .MEMCLK     (MEMCLK),
    .RESET_n    (RESET_n),
    .ram_busy   (ram_busy),
    .ram_req    (ram_req),
    .owns_bus   (owns_bus),
    .ref_hold   (ref_hold),
    .init_done  (init_done),
    .ref_overrun(ref_overrun),
    .CKE        (CKE),
    .CS_n       (CS_n),
    .RAS_n      (RAS_n),
    .CAS_n      (CAS_n),
    .WE_n       (WE_n),
    .MA         (MA),
    .BA         (BA)
  );

  typedef struct {
    int          e;
    logic [3:0]  cmd;
    logic [11:0] ma;
  } exp_cmd_t;

  exp_cmd_t sb_q[$];

  int   n_checks  = 0;
  int   n_errors  = 0;
  int   m_edge    = -1;
  int   m_next    = 0;
  int   m_owed    = 0;
  int   m_ref_end = D - 1;
  bit   m_ovr     = 1'b0;
  logic e_owns = 1'b1, e_hold = 1'b1, e_done = 1'b0, e_ovr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, m_edge);
    end
  endtask

  function automatic exp_cmd_t mk(input int e, input logic [3:0] c, input logic [11:0] a);
    exp_cmd_t x;
    x.e   = e;
    x.cmd = c;
    x.ma  = a;
    return x;
  endfunction

  // Reference model: init schedule and refresh arbitration by plain arithmetic.
  always @(posedge MEMCLK) begin
    int e;
    bit grant, tick;
    if (!RESET_n) begin
      m_edge    = -1;
      m_next    = 0;
      m_owed    = 0;
      m_ovr     = 1'b0;
      m_ref_end = D - 1;
      sb_q.delete();
      sb_q.push_back(mk(W, C_PRE, 12'h400));
      for (int i = 0; i < NREF; i++) sb_q.push_back(mk(W + TRP + i * TRC, C_REF, 12'h000));
      sb_q.push_back(mk(W + TRP + NREF * TRC, C_MRS, MODE));
      e_owns = 1'b1; e_hold = 1'b1; e_done = 1'b0; e_ovr = 1'b0;
    end else begin
      e      = m_next;
      m_next = m_next + 1;
      m_edge = e;
      grant  = 1'b0;
      if (e >= D) begin
        if (e > m_ref_end)
          grant = (m_owed > 0) && !ram_busy && (m_owed >= 4 || !ram_req);
`ifdef SDRAM_REFRESH_BURST_EN
        else if (e == m_ref_end)
          grant = (m_owed > 0) && !ram_busy;
`endif
      end
      tick   = (e > D) && (((e - D) % RI) == 0);
      e_owns = (e <= m_ref_end);
      e_hold = e_owns || (m_owed >= 4) || grant;
      e_done = (e >= D);
      if (tick && m_owed == 8) m_ovr = 1'b1;
      if (tick && !grant) m_owed = (m_owed < 8) ? m_owed + 1 : 8;
      else if (grant && !tick) m_owed = m_owed - 1;
      e_ovr = m_ovr;
      if (grant) begin
        m_ref_end = e + TRC;
        sb_q.push_back(mk(e + 1, C_REF, 12'h000));
      end
    end
  end

  // Monitor: samples just after each edge and pops the scoreboard on commands.
  always @(posedge MEMCLK) begin
    logic [3:0] cmd;
    exp_cmd_t   x;
    #1;
    cmd = {CS_n, RAS_n, CAS_n, WE_n};
    if (m_edge < 0) begin
      check("reset_pins", {CKE, CS_n, RAS_n, CAS_n, WE_n, BA, MA}, {1'b0, 4'b1111, 2'b00, 12'h000});
      check("reset_flags", {owns_bus, ref_hold, init_done, ref_overrun}, 4'b1100);
    end else begin
      check("cke", CKE, 1'b1);
      check("owns_bus", owns_bus, e_owns);
      check("ref_hold", ref_hold, e_hold);
      check("init_done", init_done, e_done);
      check("ref_overrun", ref_overrun, e_ovr);
      if (cmd != C_NOP) begin
        if (sb_q.size() == 0) begin
          check("unexpected_cmd", cmd, C_NOP);
        end else begin
          x = sb_q.pop_front();
          check("cmd_edge", m_edge, x.e);
          check("cmd_code", cmd, x.cmd);
          if (x.cmd == C_PRE) check("pre_ma10", MA[10], 1'b1);
          if (x.cmd == C_MRS) check("mrs_ma_ba", {BA, MA}, {2'b00, x.ma});
        end
      end else if (sb_q.size() > 0 && sb_q[0].e <= m_edge) begin
        x = sb_q.pop_front();
        check("cmd_missing", cmd, x.cmd);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    bit found;
    int due;
    RESET_n  = 1'b0;
    ram_busy = 1'b0;
    ram_req  = 1'b0;
    repeat (3) @(negedge MEMCLK);
    RESET_n = 1'b1;

    // Init sequence, then idle-bus refreshes.
    repeat (D + 4 * RI) @(negedge MEMCLK);

    // Access engine keeps requesting: only urgent refreshes get through.
    ram_req = 1'b1;
    repeat (9 * RI) @(negedge MEMCLK);
    ram_req = 1'b0;
    repeat (2 * RI) @(negedge MEMCLK);

    // Engine busy for 10 intervals: owed saturates and overrun sets.
    ram_busy = 1'b1;
    repeat (10 * RI) @(negedge MEMCLK);
    check("overrun_after_saturation", ref_overrun, 1'b1);
    ram_busy = 1'b0;
    repeat (4 * RI) begin
      ram_req = 1'($urandom_range(0, 1));
      @(negedge MEMCLK);
    end
    ram_req = 1'b0;
    repeat (2 * RI) @(negedge MEMCLK);

    // Tick coinciding with REF_CMD entry while one refresh is owed.
    ram_busy = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2 * RI && !found; i++) begin
      @(negedge MEMCLK);
      if (m_owed == 1) found = 1'b1;
    end
    check("owed_reached_one", found, 1'b1);
    for (int i = 0; i < RI + 2; i++) begin
      if (((m_next - D) % RI) == 0) break;
      @(negedge MEMCLK);
    end
    ram_busy = 1'b0;
    repeat (3 * TRC) @(negedge MEMCLK);

    // Randomised traffic with varying busy density.
    for (int b = 0; b < 20; b++) begin
      int dens;
      dens = int'($urandom_range(0, 3));
      repeat (75) begin
        ram_busy = (int'($urandom_range(0, 3)) < dens);
        ram_req  = 1'($urandom_range(0, 1));
        @(negedge MEMCLK);
      end
    end
    ram_busy = 1'b0;
    ram_req  = 1'b0;

    // Reset pulsed during REF_TRC: aborts and reruns init.
    found = 1'b0;
    for (int i = 0; i < 3 * RI && !found; i++) begin
      @(negedge MEMCLK);
      if ({CS_n, RAS_n, CAS_n, WE_n} == C_REF) found = 1'b1;
    end
    check("refresh_before_reset", found, 1'b1);
    repeat (2) @(negedge MEMCLK);
    RESET_n = 1'b0;
    @(negedge MEMCLK);
    RESET_n = 1'b1;
    repeat (D + 3 * RI) @(negedge MEMCLK);

    due = 0;
    foreach (sb_q[i]) if (sb_q[i].e <= m_edge) due++;
    check("scoreboard_due_empty", due, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_init_refresh.md
# sdram_init_refresh

Power-up initialisation and periodic auto-refresh sequencer for the CIDER SDRAM. It sits between the Zorro II access engine and the SDRAM pins: it owns the command bus during the init sequence and during each refresh, and hands the bus back otherwise. It tracks owed refreshes so that Amiga bus cycles are delayed only when refresh becomes urgent.

## Interface
- INIT_WAIT_CYCLES, 20000: MEMCLK cycles of NOP after reset, before the first precharge (≥100 µs).
- REFRESH_INTERVAL, 780: MEMCLK cycles per refresh tick (7.8 µs).
- T_RP, 2: precharge-to-command cycles.
- T_RC, 7: refresh-to-command cycles.
- T_MRD, 2: mode-register-set to command cycles.
- INIT_REFRESHES, 8: auto-refreshes issued during init.
- MODE_WORD, 12'h020: value driven on MA during MRS (CAS 2, burst 1).
- MEMCLK  in  1  sole clock; everything samples on posedge.
- RESET_n  in  1  reset, synchronous active-low, sampled on posedge MEMCLK.
- ram_busy  in  1  access engine is mid-cycle (RAS issued, not yet precharged).
- ram_req  in  1  access engine wants to issue ACTIVE this cycle.
- owns_bus  out  1  this block drives the command pins; the top muxes on it.
- ref_hold  out  1  access engine must not start a new cycle.
- init_done  out  1  init complete; sticky until reset.
- ref_overrun  out  1  sticky; owed count saturated.
- CKE, CS_n, RAS_n, CAS_n, WE_n  out  1 each  SDRAM command.
- MA  out  12  SDRAM address.
- BA  out  2  SDRAM bank.

## Operation
- Commands as {CS_n,RAS_n,CAS_n,WE_n}:
  - DESELECT 1xxx
  - NOP 0111
  - PRECHARGE-ALL 0010 with MA[10]=1
  - AUTO-REFRESH 0001
  - MRS 0000 with MA=MODE_WORD, BA=0
- Every state not listed as issuing a command drives NOP.
- States:
  - INIT_WAIT: NOP for INIT_WAIT_CYCLES → INIT_PRE.
  - INIT_PRE: issue PRECHARGE-ALL for 1 cycle → INIT_TRP.
  - INIT_TRP: wait T_RP-1 cycles → INIT_REF.
  - INIT_REF: issue AUTO-REFRESH for 1 cycle → INIT_TRC.
  - INIT_TRC: wait T_RC-1 cycles, then → INIT_REF again until INIT_REFRESHES have been issued, else → INIT_MRS.
  - INIT_MRS: issue MRS for 1 cycle → INIT_TMRD.
  - INIT_TMRD: wait T_MRD-1 cycles → IDLE; set init_done.
  - IDLE: owns_bus=0; this block's command outputs drive NOP.
  - REF_CMD: issue AUTO-REFRESH for 1 cycle → REF_TRC.
  - REF_TRC: wait T_RC-1 cycles → IDLE, or → REF_CMD (see Configuration).
- owns_bus=1 in every state except IDLE.
- Refresh timer:
  - Enabled only once init_done=1.
  - Counts down from REFRESH_INTERVAL-1; at 0 it reloads and increments `owed`.
  - `owed` is 4 bits and saturates at 8. A tick arriving while owed=8 sets ref_overrun.
- Arbitration in IDLE with owed>0:
  - owed<4: enter REF_CMD only if ram_busy=0 and ram_req=0. The access engine wins ties.
  - owed≥4 (urgent): enter REF_CMD as soon as ram_busy=0, even if ram_req=1.
- `owed` decrements on entry to REF_CMD. A tick on the same edge gives a net change of 0.
- ref_hold is registered: (state≠IDLE) || (owed≥4) || (next state is REF_CMD).
- ref_hold is 1 throughout init.

## Timing
- Reset values:
  - state=INIT_WAIT, owed=0, all counters cleared.
  - CKE=0, CS_n=1 (DESELECT), RAS_n=CAS_n=WE_n=1, MA=0, BA=0.
  - owns_bus=1, ref_hold=1, init_done=0, ref_overrun=0.
- CKE rises on the first INIT_WAIT cycle after reset and stays 1.
- All outputs are registered. A command appears one cycle after its state is entered, for exactly one cycle.
- Refresh latency from an urgent grant to AUTO-REFRESH on the pins: 1 cycle. The bus returns to the access engine T_RC cycles later.
- Reset asserted mid-sequence (mid-refresh or mid-init) aborts it. The block restarts at INIT_WAIT the next cycle, and the full init sequence reruns.
- First periodic tick occurs REFRESH_INTERVAL cycles after init_done rises.

## Configuration
- SDRAM_REFRESH_BURST_EN defined: at the end of REF_TRC, if owed>0 and ram_busy=0, go straight back to REF_CMD (back-to-back drain) regardless of ram_req.
- Macro not defined: REF_TRC always returns to IDLE, so one refresh per arbitration win.

## Structure
- Shared package (globalparams.vh) holds:
  - the command encodings (CMD_NOP, CMD_PRE, CMD_REF, CMD_MRS, CMD_DESEL)
  - the state localparams
  - URGENT_THRESHOLD=4 and OWED_MAX=8
- Natural sub-module: refresh_timer. It contains the interval down-counter and the saturating `owed` credit counter, with inputs tick_en and consume, and outputs owed and overrun.

## Test plan
- Reset released with INIT_WAIT_CYCLES=16 and INIT_REFRESHES=2 → CKE=1 at cycle 1; PRECHARGE with MA[10]=1 at cycle 17; two AUTO-REFRESH commands T_RC apart; MRS with MA=12'h020; init_done=1 T_MRD cycles later.
- Idle bus, REFRESH_INTERVAL=20 → one AUTO-REFRESH every 20 cycles; owed returns to 0; ref_hold pulses for T_RC cycles.
- ram_req held 1 with owed=3 → no refresh. On the 4th tick, ref_hold=1 and refresh issues once ram_busy=0.
- ram_busy held 1 for 9 intervals → owed saturates at 8 and ref_overrun=1. On release, refreshes drain: back-to-back with SDRAM_REFRESH_BURST_EN defined, one per idle window without it.
- Tick coincides with REF_CMD entry while owed=1 → owed stays 1.
- RESET_n pulsed low during REF_TRC → outputs return to reset values next cycle and the init sequence reruns from INIT_WAIT.
